// File: rtl/friscv_inst_fetcher_pkg.sv
// friscv_h: constants shared by the instruction fetch front-end and its FIFO
package friscv_h;

    localparam int          XLEN_W        = 32;
    localparam int          ILEN_W        = 32;
    localparam logic [31:0] BOOT_ADDR_DEF = 32'h0;
    localparam logic [2:0]  ARPROT_INST   = 3'b100;
    localparam logic [1:0]  RESP_OKAY     = 2'b00;

    function automatic int cnt_w(input int n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/friscv_scfifo.sv
// friscv_scfifo: single-clock FIFO with synchronous flush and zeroed output when empty
// Ports: aclk/aresetn clock and async reset; flush clears all entries;
//        push/data_in write; pull/data_out read head; count occupancy; empty flag.
module friscv_scfifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
)(
    input  logic                     aclk,
    input  logic                     aresetn,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         data_in,
    input  logic                     pull,
    output logic [WIDTH-1:0]         data_out,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pull;

    assign empty    = count == '0;
    assign do_push  = push && count != (AW+1)'(DEPTH);
    assign do_pull  = pull && !empty;
    assign data_out = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(do_push);
            rd_ptr <= rd_ptr + AW'(do_pull);
            count  <= count + (AW+1)'(do_push) - (AW+1)'(do_pull);
        end
    end

    always_ff @(posedge aclk) begin
        if (do_push) mem[wr_ptr] <= data_in;
    end

endmodule

// File: rtl/friscv_inst_fetcher.sv
// friscv_inst_fetcher: sequential instruction fetch over AXI4-lite with redirect and stale-response drop
// Ports: aclk/aresetn/srst clock and resets; cache_ready gates requests;
//        jump_* redirect handshake; ar*/r* icache control channel; inst_* decoder handshake.
module friscv_inst_fetcher
    import friscv_h::*;
#(
    parameter int              ILEN        = ILEN_W,
    parameter int              XLEN        = XLEN_W,
    parameter int              AXI_ADDR_W  = XLEN,
    parameter int              AXI_ID_W    = 8,
    parameter int              AXI_ID_MASK = 'h10,
    parameter int              OSTDREQ_NUM = 4,
    parameter logic [XLEN-1:0] BOOT_ADDR   = XLEN'(BOOT_ADDR_DEF)
)(
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  srst,
    input  logic                  cache_ready,
    input  logic                  jump_valid,
    output logic                  jump_ready,
    input  logic [XLEN-1:0]       jump_addr,
    output logic                  arvalid,
    input  logic                  arready,
    output logic [AXI_ADDR_W-1:0] araddr,
    output logic [2:0]            arprot,
    output logic [AXI_ID_W-1:0]   arid,
    input  logic                  rvalid,
    output logic                  rready,
    input  logic [AXI_ID_W-1:0]   rid,
    input  logic [1:0]            rresp,
    input  logic [ILEN-1:0]       rdata,
    output logic                  inst_valid,
    input  logic                  inst_ready,
    output logic [XLEN-1:0]       inst_pc,
    output logic [ILEN-1:0]       inst_data,
    output logic                  inst_err
);

    localparam int CW = cnt_w(OSTDREQ_NUM);
    localparam int FW = XLEN + ILEN + 1;

    logic            active, active_nxt;
    logic            arvalid_nxt;
    logic [XLEN-1:0] fetch_pc, fetch_pc_nxt;
    logic [XLEN-1:0] resp_pc, resp_pc_nxt;
    logic [CW-1:0]   ostd, ostd_nxt;
    logic [CW-1:0]   stale, stale_nxt;
    logic [CW-1:0]   fifo_cnt, cnt_nxt;
    logic            credit;
    logic            ar_hs, r_hs, jump_hs, push, pull, fifo_empty;
    logic [FW-1:0]   fifo_q;

    assign rready     = active;
    assign jump_ready = active && !(arvalid && !arready);
    assign ar_hs      = arvalid && arready;
    assign r_hs       = rvalid && rready;
    assign jump_hs    = jump_valid && jump_ready;
    assign push       = r_hs && stale == '0;
    assign pull       = inst_valid && inst_ready;
    assign inst_valid = !fifo_empty;
    assign araddr     = AXI_ADDR_W'(fetch_pc);
    assign arprot     = ARPROT_INST;
    assign arid       = AXI_ID_W'(AXI_ID_MASK);
    assign {inst_pc, inst_data, inst_err} = fifo_q;

    // Credits are evaluated on next-cycle occupancy so a request is never
    // issued into a slot that this cycle's handshakes have not yet freed.
    always_comb begin
        ostd_nxt     = ostd + CW'(ar_hs) - CW'(r_hs);
        stale_nxt    = jump_hs ? ostd_nxt : stale - CW'(r_hs && stale != '0);
        cnt_nxt      = jump_hs ? '0 : fifo_cnt + CW'(push) - CW'(pull);
        credit       = ({1'b0, ostd_nxt} + {1'b0, cnt_nxt}) < (CW+1)'(OSTDREQ_NUM);
        arvalid_nxt  = !srst && ((arvalid && !arready) ||
                       (cache_ready && !jump_hs && stale_nxt == '0 && credit));
        active_nxt   = !srst;
        fetch_pc_nxt = srst ? BOOT_ADDR : jump_hs ? jump_addr : fetch_pc + (ar_hs ? XLEN'(4) : '0);
        resp_pc_nxt  = srst ? BOOT_ADDR : jump_hs ? jump_addr : resp_pc + (push ? XLEN'(4) : '0);
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            active   <= 1'b0;
            arvalid  <= 1'b0;
            fetch_pc <= BOOT_ADDR;
            resp_pc  <= BOOT_ADDR;
            ostd     <= '0;
            stale    <= '0;
        end else begin
            active   <= active_nxt;
            arvalid  <= arvalid_nxt;
            fetch_pc <= fetch_pc_nxt;
            resp_pc  <= resp_pc_nxt;
            ostd     <= srst ? '0 : ostd_nxt;
            stale    <= srst ? '0 : stale_nxt;
        end
    end

    friscv_scfifo #(
        .DEPTH (OSTDREQ_NUM),
        .WIDTH (FW)
    ) u_fifo (
        .aclk     (aclk),
        .aresetn  (aresetn),
        .flush    (jump_hs || srst),
        .push     (push),
        .data_in  ({resp_pc, rdata, rresp != RESP_OKAY}),
        .pull     (pull),
        .data_out (fifo_q),
        .count    (fifo_cnt),
        .empty    (fifo_empty)
    );

endmodule
